reg_bank_write_arbiter: RTL and testbench

- Shares the write port of the 20-bit register bank between `N_REQ` requesters.
- The bank is built from synchronous-reset D flip-flops with one load enable per register.
- Arbitrates pending write requests, latches the winner's address and data, and issues one write strobe into the bank.
- Returns a one-cycle acknowledge to the winner; sits between the datapath sub-blocks and the register bank.

---
 rtl/reg_bank_write_arbiter_if.sv | 28 ++
 rtl/reg_bank_write_arbiter.sv | 123 ++++++++++++
 tb/tb_reg_bank_write_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_bank_write_arbiter_if.sv
// Write-port bundle between the requesting datapath blocks and the arbiter.
// The master side raises requests; the slave side (the arbiter) grants them and drives the bank.
interface reg_bank_write_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int WIDTH  = 20,
    parameter int ADDR_W = 3
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [N_REQ-1:0]        req;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*WIDTH-1:0]  req_data;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        ack;
    logic [DEPTH-1:0]        reg_we;
    logic [WIDTH-1:0]        reg_d;
    logic                    busy;

    modport master (
        output req, req_addr, req_data,
        input  gnt, ack, reg_we, reg_d, busy
    );

    modport slave (
        input  req, req_addr, req_data,
        output gnt, ack, reg_we, reg_d, busy
    );
endinterface

// File: rtl/reg_bank_write_arbiter.sv
// Arbitrates N_REQ writers onto the single register-bank write port: IDLE/GRANT/WRITE/ACK per write.
// Define ARB_ROUND_ROBIN_EN for rotating priority; otherwise the lowest requester index always wins.
module reg_bank_write_arbiter #(
    parameter int N_REQ  = 4,
    parameter int WIDTH  = 20,
    parameter int ADDR_W = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    reg_bank_write_arbiter_if.slave       bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, WRITE, ACK} state_t;

    state_t             r_state;
    logic [N_REQ-1:0]   r_gnt;
    logic [N_REQ-1:0]   r_ack;
    logic [DEPTH-1:0]   r_reg_we;
    logic [WIDTH-1:0]   r_reg_d;
    logic               r_busy;
    logic [ADDR_W-1:0]  r_addr;

    logic [ADDR_W-1:0]  w_addr [N_REQ];
    logic [WIDTH-1:0]   w_data [N_REQ];
    logic [IDX_W-1:0]   w_win;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign w_addr[gi] = bus.req_addr[gi*ADDR_W +: ADDR_W];
            assign w_data[gi] = bus.req_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_win;
    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic [IDX_W-1:0]   w_off;
    logic [IDX_W:0]     w_sum;

    // Rotate so the pointer position sits at bit 0, find the first set bit, then rotate back.
    assign w_dbl = {bus.req, bus.req} >> r_ptr;
    assign w_rot = w_dbl[N_REQ-1:0];

    always_comb begin
        w_off = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) w_off = IDX_W'(k);
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum >= (IDX_W+1)'(N_REQ)) w_sum = w_sum - (IDX_W+1)'(N_REQ);
        w_win = w_sum[IDX_W-1:0];
    end
`else
    always_comb begin
        w_win = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (bus.req[k]) w_win = IDX_W'(k);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_ack    <= '0;
            r_reg_we <= '0;
            r_reg_d  <= '0;
            r_busy   <= 1'b0;
            r_addr   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            r_ptr    <= '0;
            r_win    <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (|bus.req) begin
                        r_state <= GRANT;
                        r_gnt   <= N_REQ'(1) << w_win;
                        r_addr  <= w_addr[w_win];
                        r_reg_d <= w_data[w_win];
                        r_busy  <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                        r_win   <= w_win;
`endif
                    end
                end
                GRANT: begin
                    r_state  <= WRITE;
                    r_reg_we <= DEPTH'(1) << r_addr;
                end
                WRITE: begin
                    r_state  <= ACK;
                    r_reg_we <= '0;
                    r_ack    <= r_gnt;
                end
                ACK: begin
                    r_state <= IDLE;
                    r_ack   <= '0;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
                    r_ptr   <= (r_win == IDX_W'(N_REQ - 1)) ? '0 : r_win + 1'b1;
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Strobe and acknowledge are masked by reset so an aborted write never lands in the bank.
    assign bus.gnt    = r_gnt;
    assign bus.ack    = r_ack & {N_REQ{~rst}};
    assign bus.reg_we = r_reg_we & {DEPTH{~rst}};
    assign bus.reg_d  = r_reg_d;
    assign bus.busy   = r_busy;
endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// Scoreboard bench for reg_bank_write_arbiter: directed test-plan cases followed by random traffic.
module tb_reg_bank_write_arbiter;
    localparam int N = 4;
    localparam int W = 20;
    localparam int A = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_bank_write_arbiter_if #(.N_REQ(N), .WIDTH(W), .ADDR_W(A)) bus ();

    reg_bank_write_arbiter #(.N_REQ(N), .WIDTH(W), .ADDR_W(A)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int t;
        int win;
        int addr;
        int data;
    } txn_t;

    txn_t we_q[$];
    txn_t ack_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_n  = 0;

    always @(posedge clk) cyc_n++;

    function automatic void check(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endfunction

    // Reference arbitration: first requesting index at or after the pointer, wrapping.
    function automatic int pick(logic [N-1:0] r, int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return 0;
    endfunction

    // Transaction-level model: a request seen in a free cycle T owns cycles T+1..T+3.
    int   m_ptr  = 0;
    int   t_last = -100;
    txn_t cur;

    always @(negedge clk) begin : model
        int c;
        int w;
        bit act;
        c = cyc_n;
        if (rst) begin
            m_ptr  = 0;
            t_last = -100;
            we_q.delete();
            ack_q.delete();
        end else begin
            act = (c >= t_last + 1) && (c <= t_last + 3);
            check("gnt", bus.gnt, act ? (longint'(1) << cur.win) : 0);
            check("busy", bus.busy, act ? 1 : 0);
            if (act) check("reg_d_stable", bus.reg_d, cur.data);
            if (c >= t_last + 4 && bus.req != '0) begin
                w = pick(bus.req, m_ptr);
                cur.t    = c;
                cur.win  = w;
                cur.addr = int'(bus.req_addr[w*A +: A]);
                cur.data = int'(bus.req_data[w*W +: W]);
                we_q.push_back(cur);
                ack_q.push_back(cur);
                t_last = c;
`ifdef ARB_ROUND_ROBIN_EN
                m_ptr = (w + 1) % N;
`endif
            end
        end
    end

    always @(negedge clk) begin : monitor
        txn_t e;
        check("gnt_onehot0", $onehot0(bus.gnt), 1);
        check("we_onehot0", $onehot0(bus.reg_we), 1);
        if (rst) begin
            check("rst_reg_we", bus.reg_we, 0);
            check("rst_ack", bus.ack, 0);
        end else begin
            if (bus.reg_we != '0) begin
                if (we_q.size() == 0) begin
                    check("spurious_reg_we", bus.reg_we, 0);
                end else begin
                    e = we_q.pop_front();
                    check("reg_we", bus.reg_we, longint'(1) << e.addr);
                    check("reg_d", bus.reg_d, e.data);
                    check("we_timing", cyc_n, e.t + 2);
                end
            end
            if (bus.ack != '0) begin
                if (ack_q.size() == 0) begin
                    check("spurious_ack", bus.ack, 0);
                end else begin
                    e = ack_q.pop_front();
                    check("ack", bus.ack, longint'(1) << e.win);
                    check("ack_timing", cyc_n, e.t + 3);
                    $display("txn cycle %0d: requester %0d addr %0d data 0x%05h", e.t, e.win, e.addr, e.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int i, int addr, int data);
        bus.req_addr[i*A +: A] = A'(addr);
        bus.req_data[i*W +: W] = W'(data);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((bus.busy || we_q.size() != 0 || ack_q.size() != 0) && n < 40) begin
            step();
            n++;
        end
        check("idle_timeout", n < 40, 1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        bus.req      = '0;
        bus.req_addr = '0;
        bus.req_data = '0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        // Quiet period after reset
        repeat (10) begin
            step();
            check("idle_gnt", bus.gnt, 0);
            check("idle_ack", bus.ack, 0);
            check("idle_reg_we", bus.reg_we, 0);
            check("idle_reg_d", bus.reg_d, 0);
            check("idle_busy", bus.busy, 0);
        end

        // Single request: requester 0, addr 5, data 0xABCDE
        set_req(0, 5, 'hABCDE);
        bus.req = 4'b0001;
        step(); check("t1_gnt", bus.gnt, 'b0001); check("t1_busy", bus.busy, 1);
        step(); check("t2_reg_we", bus.reg_we, 'h20); check("t2_reg_d", bus.reg_d, 'hABCDE);
        step(); check("t3_ack", bus.ack, 'b0001);
        bus.req = '0;
        step(); check("t4_busy", bus.busy, 0);
        wait_idle();

        // All four held: grant order depends on the build
        pulse_reset();
        for (int i = 0; i < N; i++) set_req(i, i + 1, 'h10000 + i);
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
`ifdef ARB_ROUND_ROBIN_EN
            check("hold_all_gnt", bus.gnt, longint'(1) << (k % N));
`else
            check("hold_all_gnt", bus.gnt, 'b0001);
`endif
            repeat (3) step();
        end
        bus.req = '0;
        wait_idle();

        // Requester 2 drops req and every payload changes during WRITE
        set_req(2, 3, 'h12345);
        bus.req = 4'b0100;
        step(); check("drop_gnt", bus.gnt, 'b0100);
        step();
        bus.req = '0;
        set_req(2, 7, 'hFFFFF);
        set_req(0, 1, 'h00001);
        check("drop_reg_we", bus.reg_we, 'h08);
        check("drop_reg_d", bus.reg_d, 'h12345);
        step(); check("drop_ack", bus.ack, 'b0100);
        wait_idle();

        // Reset lands in the WRITE cycle
        set_req(2, 6, 'h55555);
        bus.req = 4'b0100;
        step();
        step();
        rst = 1'b1;
        bus.req = '0;
        #1;
        check("abort_reg_we", bus.reg_we, 0);
        check("abort_ack", bus.ack, 0);
        step();
        check("abort_gnt", bus.gnt, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_reg_we_after", bus.reg_we, 0);
        check("abort_reg_d", bus.reg_d, 0);
        rst = 1'b0;
        set_req(1, 1, 'h0F0F0);
        bus.req = 4'b0010;
        step(); check("post_rst_gnt", bus.gnt, 'b0010);
        step(); check("post_rst_ack_none", bus.ack, 0);
        step(); check("post_rst_ack", bus.ack, 'b0010);
        bus.req = '0;
        wait_idle();

        // Random traffic: level-held requests, payloads churning every cycle
        repeat (600) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (bus.req[i]) begin
                    if (bus.ack[i]) begin
                        if ($urandom_range(3) != 0) bus.req[i] = 1'b0;
                    end else if (bus.gnt[i] && $urandom_range(7) == 0) begin
                        bus.req[i] = 1'b0;
                    end
                end else if ($urandom_range(3) == 0) begin
                    bus.req[i] = 1'b1;
                end
                if ($urandom_range(1) == 1) set_req(i, int'($urandom_range(7)), int'($urandom_range(20'hFFFFF)));
            end
        end
        bus.req = '0;
        wait_idle();
        check("drain", we_q.size() + ack_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
